// File: rtl/mem_stage_wait_ctrl_pkg.sv
// Purpose: shared types and constants for the MEM stage and its data memory.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arm_mem_pkg;

  localparam int DATA_W            = 32;
  localparam int REG_IDX_W         = 4;
  localparam int WAIT_CNT_W        = 4;
  localparam int DEFAULT_BASE_ADDR = 1024;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_stage_wait_ctrl_if.sv
// Purpose: bundle of EXE->MEM inputs and MEM->WB outputs of the MEM stage.
// Latency: n/a (wires only).
// Backpressure: freeze travels back to upstream through this bundle.
interface mem_stage_wait_ctrl_if;
  import arm_mem_pkg::*;

  logic                 writeBackEnIn;
  logic                 memReadIn;
  logic                 memWriteIn;
  logic [DATA_W-1:0]    ALUResultIn;
  logic [DATA_W-1:0]    storeValueIn;
  logic [REG_IDX_W-1:0] destinationIn;

  logic                 writeBackEn;
  logic                 memRead;
  logic [DATA_W-1:0]    ALUResult;
  logic [DATA_W-1:0]    memData;
  logic [REG_IDX_W-1:0] destination;
  logic                 freeze;
  logic                 accessErr;

  // Upstream pipeline side: drives the instruction, observes results/stall.
  modport master (
    output writeBackEnIn, memReadIn, memWriteIn, ALUResultIn, storeValueIn, destinationIn,
    input  writeBackEn, memRead, ALUResult, memData, destination, freeze, accessErr
  );

  // MEM stage side.
  modport slave (
    input  writeBackEnIn, memReadIn, memWriteIn, ALUResultIn, storeValueIn, destinationIn,
    output writeBackEn, memRead, ALUResult, memData, destination, freeze, accessErr
  );

endinterface

// File: rtl/mem_stage_wait_ctrl_data_memory_array.sv
// Purpose: DEPTH x 32 word array, synchronous write, registered read port.
// Latency: write and read both take effect on the enabling clock edge.
// Backpressure: none; the caller decides when to enable.
module data_memory_array
  import arm_mem_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic                     re,
  input  logic                     rd_clr,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage: cleared on reset, written only when the access edge enables it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[idx] <= wdata;
    end
  end

  // Read register: holds the last load; rd_clr returns zero for a miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (rd_clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/mem_stage_wait_ctrl.sv
// Purpose: MEM pipeline stage fronting a slow data memory via a wait-state FSM.
// Latency: memory ops occupy WAIT_CYCLES+2 cycles; non-memory ops pass through in 0.
// Backpressure: freeze held high from request until the DONE cycle, stalling upstream.
module mem_stage_wait_ctrl
  import arm_mem_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int WAIT_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_stage_wait_ctrl_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);

  mem_state_e            state;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  access_err;

  logic                  req;
  logic                  in_range;
  logic                  do_access;
  logic                  is_load;
  logic [DATA_W-1:0]     offset;
  logic [IDX_W-1:0]      word_idx;
  logic [DATA_W-1:0]     rdata;

  assign req      = bus.memReadIn | bus.memWriteIn;
  // Offset from the window base; range test on the offset avoids overflow of base+size.
  assign offset   = bus.ALUResultIn - DATA_W'(BASE_ADDR);
  assign in_range = (bus.ALUResultIn >= DATA_W'(BASE_ADDR)) && (offset < DATA_W'(4 * DEPTH));
  assign word_idx = offset[IDX_W+1:2];

  // Store wins when both read and write are requested, so it is not a load.
  assign is_load   = bus.memReadIn & ~bus.memWriteIn;
  assign do_access = (state == ACCESS) && (wait_cnt == '0);

  // Wait-state sequencer: IDLE -> ACCESS (count down) -> DONE -> IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state    <= ACCESS;
            wait_cnt <= WAIT_CNT_W'(WAIT_CYCLES - 1);
          end
        end
        ACCESS: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WAIT_CNT_W'(1);
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Sticky out-of-range flag, set on the edge the access would have happened.
  always_ff @(posedge clk) begin
    if (rst) begin
      access_err <= 1'b0;
    end else if (do_access && !in_range) begin
      access_err <= 1'b1;
    end
  end

  data_memory_array #(
    .DEPTH (DEPTH)
  ) u_dmem (
    .clk    (clk),
    .rst    (rst),
    .we     (do_access & bus.memWriteIn & in_range),
    .re     (do_access & is_load & in_range),
    .rd_clr (do_access & is_load & ~in_range),
    .idx    (word_idx),
    .wdata  (bus.storeValueIn),
    .rdata  (rdata)
  );

  // DONE releases the stall so upstream advances exactly once per access.
  assign bus.freeze      = req && (state != DONE) && !rst;
  assign bus.writeBackEn = bus.writeBackEnIn;
  assign bus.memRead     = bus.memReadIn;
  assign bus.ALUResult   = bus.ALUResultIn;
  assign bus.destination = bus.destinationIn;
  assign bus.memData     = rdata;
  assign bus.accessErr   = access_err;

endmodule

// File: tb/tb_mem_stage_wait_ctrl.sv
module tb_mem_stage_wait_ctrl;

  localparam int DEPTH = 64;
  localparam int BASE  = 1024;
  localparam int W     = 3;

  logic clk;
  logic rst;

  logic        d_wbe, d_rd, d_wr;
  logic [31:0] d_addr, d_val;
  logic [3:0]  d_dst;

  mem_stage_wait_ctrl_if bus ();

  assign bus.writeBackEnIn = d_wbe;
  assign bus.memReadIn     = d_rd;
  assign bus.memWriteIn    = d_wr;
  assign bus.ALUResultIn   = d_addr;
  assign bus.storeValueIn  = d_val;
  assign bus.destinationIn = d_dst;

  mem_stage_wait_ctrl #(
    .DEPTH       (DEPTH),
    .BASE_ADDR   (BASE),
    .WAIT_CYCLES (W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: phase within the current occupancy plus memory contents.
  logic [31:0] mem_m [DEPTH];
  logic [31:0] md_m;
  logic        err_m;
  int          ph;

  logic        dut_frz_s;
  logic        exp_frz_s;
  logic [31:0] dut_md_s;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic model_freeze();
    int cur;
    cur = (ph < 0) ? 0 : ph;
    return !rst && (d_rd || d_wr) && (cur <= W);
  endfunction

  task automatic model_update();
    int          cur;
    logic [31:0] off;
    logic        inr;
    int          idx;
    if (rst) begin
      ph    = -1;
      md_m  = '0;
      err_m = 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    end else if (d_rd || d_wr || ph >= 0) begin
      cur = (ph < 0) ? 0 : ph;
      if (cur == W) begin
        off = d_addr - 32'(BASE);
        inr = (d_addr >= 32'(BASE)) && (off < 32'(4 * DEPTH));
        idx = int'(off >> 2);
        if (!inr) err_m = 1'b1;
        if (d_wr) begin
          if (inr) mem_m[idx] = d_val;
        end else if (d_rd) begin
          md_m = inr ? mem_m[idx] : 32'h0;
        end
      end
      ph = (cur == W + 1) ? -1 : cur + 1;
    end
  endtask

  task automatic check_all();
    exp_frz_s = model_freeze();
    dut_frz_s = bus.freeze;
    dut_md_s  = bus.memData;
    chk("freeze",      32'(bus.freeze),      32'(exp_frz_s));
    chk("writeBackEn", 32'(bus.writeBackEn), 32'(d_wbe));
    chk("memRead",     32'(bus.memRead),     32'(d_rd));
    chk("ALUResult",   bus.ALUResult,        d_addr);
    chk("destination", 32'(bus.destination), 32'(d_dst));
    chk("memData",     bus.memData,          md_m);
    chk("accessErr",   32'(bus.accessErr),   32'(err_m));
  endtask

  // One clock: compare on the falling edge, advance the model on the rising edge.
  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Present one instruction and hold it until the stage releases it.
  task automatic issue(input logic wbe, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] v, input logic [3:0] dst,
                       output int nfrz, output int ncyc, output logic [31:0] md_done);
    bit released;
    d_wbe = wbe; d_rd = rd; d_wr = wr; d_addr = a; d_val = v; d_dst = dst;
    nfrz = 0; ncyc = 0; md_done = 'x; released = 0;
    for (int k = 0; k < 40 && !released; k++) begin
      cycle();
      ncyc++;
      if (dut_frz_s) nfrz++;
      if (!exp_frz_s) begin
        released = 1;
        md_done  = dut_md_s;
      end
    end
    if (!released) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: instruction at 0x%08h never released", a);
    end
  endtask

  task automatic set_nop();
    d_wbe = 0; d_rd = 0; d_wr = 0; d_addr = 0; d_val = 0; d_dst = 0;
  endtask

  int          nf, nc;
  logic [31:0] md;

  initial begin
    rst = 1'b1;
    set_nop();
    ph = -1; md_m = '0; err_m = 1'b0;
    @(posedge clk);
    model_update();
    #1;
    cycle();
    rst = 1'b0;
    #1;
    chk("reset_freeze",    32'(bus.freeze),    32'h0);
    chk("reset_memData",   bus.memData,        32'h0);
    chk("reset_accessErr", 32'(bus.accessErr), 32'h0);

    // Non-memory op passes straight through.
    issue(1, 0, 0, 32'h55, 32'h0, 4'd7, nf, nc, md);
    chk("nop_frz_cycles", 32'(nf), 32'd0);
    chk("nop_wbe",        32'(bus.writeBackEn), 32'd1);
    chk("nop_alu",        bus.ALUResult,        32'h55);
    chk("nop_dst",        32'(bus.destination), 32'd7);

    // Store then load.
    issue(0, 0, 1, 32'd1028, 32'hDEADBEEF, 4'd0, nf, nc, md);
    chk("st_frz_cycles", 32'(nf), 32'd4);
    issue(1, 1, 0, 32'd1028, 32'h0, 4'd3, nf, nc, md);
    chk("ld_frz_cycles", 32'(nf), 32'd4);
    chk("ld_done_data",  md, 32'hDEADBEEF);
    chk("ld_done_wbe",   32'(bus.writeBackEn), 32'd1);

    // Out-of-range load: first byte past the window.
    issue(1, 1, 0, 32'd1024 + 32'd256, 32'h0, 4'd2, nf, nc, md);
    chk("oor_data", md, 32'h0);
    chk("oor_err",  32'(bus.accessErr), 32'd1);

    // Back-to-back loads.
    issue(0, 0, 1, 32'd1024, 32'h11, 4'd0, nf, nc, md);
    issue(0, 0, 1, 32'd1028, 32'h22, 4'd0, nf, nc, md);
    issue(1, 1, 0, 32'd1024, 32'h0, 4'd1, nf, nc, md);
    chk("b2b0_data",   md, 32'h11);
    chk("b2b0_cycles", 32'(nc), 32'd5);
    issue(1, 1, 0, 32'd1028, 32'h0, 4'd1, nf, nc, md);
    chk("b2b1_data",   md, 32'h22);
    chk("b2b1_cycles", 32'(nc), 32'd5);
    chk("b2b1_frz",    32'(nf), 32'd4);
    chk("err_sticky",  32'(bus.accessErr), 32'd1);

    // Read and write together behave as a store.
    issue(0, 1, 1, 32'd1036, 32'hA5A5A5A5, 4'd0, nf, nc, md);
    chk("both_md_held", md, 32'h22);
    issue(1, 1, 0, 32'd1036, 32'h0, 4'd4, nf, nc, md);
    chk("both_readback", md, 32'hA5A5A5A5);

    // Reset during the second ACCESS cycle of a store.
    d_wbe = 0; d_rd = 0; d_wr = 1; d_addr = 32'd1032; d_val = 32'h1234; d_dst = 0;
    cycle();
    cycle();
    rst = 1'b1;
    #1;
    chk("rst_freeze", 32'(bus.freeze), 32'h0);
    cycle();
    rst = 1'b0;
    set_nop();
    cycle();
    issue(1, 1, 0, 32'd1032, 32'h0, 4'd5, nf, nc, md);
    chk("rst_abort_data", md, 32'h0);
    chk("rst_err_clear",  32'(bus.accessErr), 32'd0);

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      int          op, sel;
      logic [31:0] a;
      op  = $urandom_range(0, 9);
      sel = $urandom_range(0, 9);
      if (sel < 8)       a = 32'(BASE) + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
      else if (sel == 8) a = 32'(BASE + 4 * DEPTH) + 32'($urandom_range(0, 63));
      else               a = 32'($urandom_range(0, BASE - 1));
      if ($urandom_range(0, 59) == 0) begin
        d_wbe = 0; d_rd = 1; d_wr = op[0]; d_addr = a; d_val = $urandom; d_dst = 0;
        for (int k = 0; k < $urandom_range(1, W); k++) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        set_nop();
      end else begin
        issue(1'($urandom_range(0, 1)), (op >= 3 && op <= 5) || op == 9, op >= 6,
              a, $urandom, 4'($urandom_range(0, 15)), nf, nc, md);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
